// File: rtl/arb_pkt_mux.sv
// arb_pkt_mux: packet-level N:1 multiplexer sitting behind a round-robin
// arbiter. Requests arbitration, latches the winner from the arbiter's
// registered grant, then forwards that source's beats to the master port
// until its last beat (or the beat limit). While a packet is in flight the
// request vector is held at the owner, so the arbiter's pointer moves once
// per packet.
module arb_pkt_mux #(
   parameter  int N         = 5,
   parameter  int W         = 8,
   parameter  int MAX_BEATS = 16,
   localparam int SW        = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    s_valid,
   input  logic [N-1:0]    s_last,
   input  logic [N*W-1:0]  s_data,
   output logic [N-1:0]    s_ready,
   output logic [N-1:0]    arb_req,
   input  logic [N-1:0]    arb_grant,
   output logic            m_valid,
   output logic [W-1:0]    m_data,
   output logic            m_last,
   input  logic            m_ready,
   output logic [SW-1:0]   m_src,
   output logic            err_trunc
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [N-1:0]  owner_reg, owner_next;
   logic [N-1:0]  last_owner_reg, last_owner_next;
   logic [CW-1:0] beat_cnt_reg, beat_cnt_next;
   logic          err_trunc_reg, err_trunc_next;

   logic [W-1:0]  data_masked [N];
   logic [W-1:0]  data_sel;
   logic [SW-1:0] owner_idx;
   logic [N-1:0]  grant_cand;
   logic [N-1:0]  grant_pick;
   logic [CW-1:0] beat_inc;
   logic          in_xfer;
   logic          owner_valid;
   logic          owner_last;
   logic          at_limit;
   logic          accept;
   logic          pkt_end;

   // Zero every lane except the owner's so the data mux is a plain OR tree.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         assign data_masked[gi] = s_data[gi*W +: W] & {W{owner_reg[gi]}};
      end
   endgenerate

   // Owner data select and one-hot to binary conversion of the owner.
   always_comb begin
      data_sel  = '0;
      owner_idx = '0;
      for (int i = 0; i < N; i++) begin
         data_sel = data_sel | data_masked[i];
         if (owner_reg[i]) owner_idx = SW'(i);
      end
   end

   // A misbehaving arbiter may grant several bits; keep only the lowest valid one.
   assign grant_cand = arb_grant & s_valid;
   assign grant_pick = grant_cand & (~grant_cand + N'(1));

   assign in_xfer     = (state_reg == ST_XFER);
   assign owner_valid = |(s_valid & owner_reg);
   assign owner_last  = |(s_last & owner_reg);
   assign beat_inc    = beat_cnt_reg + CW'(1);
   assign at_limit    = (beat_inc == CW'(MAX_BEATS));
   assign accept      = m_valid & m_ready;
   assign pkt_end     = accept & (owner_last | at_limit);

   // Master side is a combinational pass-through from the owner during XFER.
   always_comb begin
      s_ready   = in_xfer ? (owner_reg & {N{m_ready}}) : '0;
      m_valid   = in_xfer & owner_valid;
      m_data    = data_sel;
      m_src     = owner_idx;
      m_last    = m_valid & (owner_last | at_limit);
      err_trunc = err_trunc_reg;
   end

   // Packet FSM: request, wait for the registered grant, then transfer.
   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      beat_cnt_next   = beat_cnt_reg;
      err_trunc_next  = 1'b0;
      arb_req         = '0;
      case (state_reg)
         ST_IDLE: begin
            // With nothing pending, re-request the last owner so the arbiter keeps its pointer.
            arb_req = (|s_valid) ? s_valid : last_owner_reg;
            if (|s_valid) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            arb_req = arb_grant;
            if (|grant_cand) begin
               owner_next    = grant_pick;
               beat_cnt_next = '0;
               state_next    = ST_XFER;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_XFER: begin
            arb_req = owner_reg;
            if (accept) beat_cnt_next = beat_inc;
            if (pkt_end) begin
               last_owner_next = owner_reg;
               state_next      = ST_IDLE;
            end
            err_trunc_next = accept & at_limit & ~owner_last;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= '0;
         last_owner_reg <= '0;
         beat_cnt_reg   <= '0;
         err_trunc_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         beat_cnt_reg   <= beat_cnt_next;
         err_trunc_reg  <= err_trunc_next;
      end
   end

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed bench for arb_pkt_mux with a small round-robin arbiter model and
// per-source beat queues. Beats seen on the master port are logged and
// compared against hand-derived sequences.
module tb_arb_pkt_mux;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  s_valid, s_last, s_ready, arb_req, arb_grant;
   logic [N*W-1:0] s_data;
   logic          m_valid, m_last, m_ready, err_trunc;
   logic [W-1:0]  m_data;
   logic [2:0]    m_src;

   arb_pkt_mux #(.N(N), .W(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
      .arb_req(arb_req), .arb_grant(arb_grant),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .m_src(m_src), .err_trunc(err_trunc)
   );

   always #5 clk = ~clk;

   // Round-robin arbiter model: registered grant, pointer is its own last grant.
   function automatic logic [N-1:0] rr(input logic [N-1:0] req, input logic [N-1:0] last);
      int p;
      int idx;
      logic [N-1:0] g;
      p = -1;
      g = '0;
      for (int i = 0; i < N; i++) if (last[i]) p = i;
      for (int k = 0; k < N; k++) begin
         idx = (p + 1 + k) % N;
         if (req[idx] && g == '0) g[idx] = 1'b1;
      end
      return g;
   endfunction

   always @(posedge clk) begin
      if (rst) arb_grant <= '0;
      else     arb_grant <= rr(arb_req, arb_grant);
   end

   // Source queues: {last, data} per entry.
   logic [8:0] mem [N][16];
   int rd [N];
   int wr [N];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_obs = 0;
   int n_err = 0;
   int err_cyc = 0;
   logic [7:0] obs_data [64];
   logic       obs_last [64];
   logic [2:0] obs_src  [64];
   int         obs_cyc  [64];
   logic [N-1:0] acc;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      mem[s][wr[s]] = {l, d};
      wr[s]++;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         s_valid[i] = (rd[i] < wr[i]);
         if (rd[i] < 16) begin
            s_data[i*W +: W] = mem[i][rd[i]][7:0];
            s_last[i]        = mem[i][rd[i]][8];
         end else begin
            s_data[i*W +: W] = '0;
            s_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      cyc++;
      acc = s_valid & s_ready;
      if (err_trunc) begin
         n_err++;
         err_cyc = cyc;
         $display("err_trunc cyc=%0d", cyc);
      end
      if (m_valid && m_ready) begin
         if (n_obs < 64) begin
            obs_data[n_obs] = m_data;
            obs_last[n_obs] = m_last;
            obs_src[n_obs]  = m_src;
            obs_cyc[n_obs]  = cyc;
         end
         $display("beat cyc=%0d src=%0d data=0x%02h last=%0b", cyc, m_src, m_data, m_last);
         n_obs++;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) rd[i]++;
      drive();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         sample();
         advance();
      end
   endtask

   task automatic clear_log();
      n_obs = 0;
      n_err = 0;
   endtask

   int ord [3] = '{3, 0, 1};

   initial begin
      for (int i = 0; i < N; i++) begin
         rd[i] = 0;
         wr[i] = 0;
         for (int j = 0; j < 16; j++) mem[i][j] = '0;
      end
      rst = 1'b1;
      m_ready = 1'b1;
      s_valid = '0; s_last = '0; s_data = '0;
      drive();
      @(posedge clk); #1;

      // Reset state.
      sample();
      check_val("rst_m_valid", {31'd0, m_valid}, 0);
      check_val("rst_s_ready", {27'd0, s_ready}, 0);
      check_val("rst_m_last", {31'd0, m_last}, 0);
      check_val("rst_arb_req", {27'd0, arb_req}, 0);
      check_val("rst_err_trunc", {31'd0, err_trunc}, 0);
      advance();
      rst = 1'b0;

      // Test 1: single 3-beat packet from source 2.
      clear_log();
      push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
      drive();
      sample();
      check_val("t1_idle_req", {27'd0, arb_req}, 32'h04);
      check_val("t1_idle_mvalid", {31'd0, m_valid}, 0);
      advance();
      sample();
      check_val("t1_wait_mvalid", {31'd0, m_valid}, 0);
      advance();
      sample();
      check_val("t1_first_valid", {31'd0, m_valid}, 1);
      check_val("t1_first_src", {29'd0, m_src}, 2);
      check_val("t1_s_ready", {27'd0, s_ready}, 32'h04);
      advance();
      run(4);
      check_val("t1_nbeats", n_obs, 3);
      check_val("t1_d0", obs_data[0], 8'hA1);
      check_val("t1_d1", obs_data[1], 8'hA2);
      check_val("t1_d2", obs_data[2], 8'hA3);
      check_val("t1_last0", {31'd0, obs_last[0]}, 0);
      check_val("t1_last1", {31'd0, obs_last[1]}, 0);
      check_val("t1_last2", {31'd0, obs_last[2]}, 1);
      check_val("t1_contig", obs_cyc[2] - obs_cyc[0], 2);

      // Test 2: sources 0,1,3 each with two 2-beat packets; pointer starts after 2.
      clear_log();
      for (int k = 0; k < 4; k++) begin
         push(0, 8'(8'h00 + k), 1'(k % 2));
         push(1, 8'(8'h10 + k), 1'(k % 2));
         push(3, 8'(8'h30 + k), 1'(k % 2));
      end
      drive();
      run(30);
      check_val("t2_nbeats", n_obs, 12);
      for (int p = 0; p < 6; p++) begin
         for (int b = 0; b < 2; b++) begin
            check_val("t2_src", {29'd0, obs_src[2*p+b]}, ord[p%3]);
            check_val("t2_data", {24'd0, obs_data[2*p+b]}, ord[p%3]*16 + 2*(p/3) + b);
            check_val("t2_last", {31'd0, obs_last[2*p+b]}, b);
         end
         check_val("t2_contig", obs_cyc[2*p+1] - obs_cyc[2*p], 1);
      end

      // Test 3: source 4 owns the port, source 0 shows up mid-packet, m_ready toggles.
      clear_log();
      push(4, 8'hC0, 1'b0); push(4, 8'hC1, 1'b0); push(4, 8'hC2, 1'b1);
      drive();
      run(2);
      push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b1);
      drive();
      sample();
      check_val("t3_c0", m_data, 8'hC0);
      advance(); m_ready = 1'b0;
      sample();
      check_val("t3_stall_valid", {31'd0, m_valid}, 1);
      check_val("t3_stall_data", m_data, 8'hC1);
      check_val("t3_stall_src", {29'd0, m_src}, 4);
      check_val("t3_stall_sready", {27'd0, s_ready}, 0);
      advance(); m_ready = 1'b1;
      sample();
      advance(); m_ready = 1'b0;
      sample();
      check_val("t3_stall2_data", m_data, 8'hC2);
      check_val("t3_stall2_last", {31'd0, m_last}, 1);
      advance(); m_ready = 1'b1;
      run(8);
      check_val("t3_nbeats", n_obs, 5);
      check_val("t3_d2", obs_data[2], 8'hC2);
      check_val("t3_s2", {29'd0, obs_src[2]}, 4);
      check_val("t3_d3", obs_data[3], 8'h50);
      check_val("t3_s3", {29'd0, obs_src[3]}, 0);
      check_val("t3_d4", obs_data[4], 8'h51);
      check_val("t3_gap", obs_cyc[3] - obs_cyc[2], 3);

      // Test 4: 6-beat packet from source 1 is cut at the 4-beat limit.
      clear_log();
      for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k), (k == 5));
      drive();
      run(16);
      check_val("t4_nbeats", n_obs, 6);
      check_val("t4_last2", {31'd0, obs_last[2]}, 0);
      check_val("t4_last3", {31'd0, obs_last[3]}, 1);
      check_val("t4_last4", {31'd0, obs_last[4]}, 0);
      check_val("t4_last5", {31'd0, obs_last[5]}, 1);
      check_val("t4_d4", obs_data[4], 8'h14);
      check_val("t4_err_cnt", n_err, 1);
      check_val("t4_err_cyc", err_cyc - obs_cyc[3], 1);
      check_val("t4_gap", obs_cyc[4] - obs_cyc[3], 3);

      // Test 5: reset during beat 2 of a 5-beat packet from source 2.
      clear_log();
      for (int k = 0; k < 5; k++) push(2, 8'(8'h20 + k), (k == 4));
      drive();
      run(3);
      rst = 1'b1;
      sample();
      advance();
      rst = 1'b0;
      sample();
      check_val("t5_mvalid", {31'd0, m_valid}, 0);
      check_val("t5_sready", {27'd0, s_ready}, 0);
      check_val("t5_idle_req", {27'd0, arb_req}, 32'h04);
      advance();
      run(10);
      check_val("t5_nbeats", n_obs, 5);
      check_val("t5_d2", obs_data[2], 8'h22);
      check_val("t5_s2", {29'd0, obs_src[2]}, 2);
      check_val("t5_regap", obs_cyc[2] - obs_cyc[1], 3);
      check_val("t5_d4", obs_data[4], 8'h24);
      check_val("t5_last4", {31'd0, obs_last[4]}, 1);
      check_val("t5_no_err", n_err, 0);

      // Test 6: idle after source 3, then 3 and 4 compete; 4 wins.
      clear_log();
      push(3, 8'h3A, 1'b1);
      drive();
      run(4);
      for (int k = 0; k < 10; k++) begin
         sample();
         check_val("t6_hold_req", {27'd0, arb_req}, 32'h08);
         advance();
      end
      push(3, 8'h3B, 1'b1);
      push(4, 8'h4B, 1'b1);
      drive();
      run(12);
      check_val("t6_nbeats", n_obs, 3);
      check_val("t6_first_src", {29'd0, obs_src[1]}, 4);
      check_val("t6_first_data", obs_data[1], 8'h4B);
      check_val("t6_second_src", {29'd0, obs_src[2]}, 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/arb_pkt_mux.md
# arb_pkt_mux

Packet-level data multiplexer that sits directly downstream of the round-robin arbiter (one-hot `grant` per cycle, registered, priority pointer carried in its own last grant). It collects N valid/ready packet sources, drives the arbiter's request vector, latches the winner on the arbiter's registered grant, and forwards that source's beats to one master port until the last beat. It holds the arbiter's grant on the owner for the whole packet so the arbiter's round-robin pointer advances once per packet, not once per beat.

## Interface
- `N`, 5: number of sources; must be ≥2 and match the arbiter.
- `W`, 8: data width per beat.
- `MAX_BEATS`, 16: beat limit per packet; at this many beats the packet is forcibly terminated.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  N  per-source beat valid; must stay high until accepted.
- `s_last`  in  N  per-source last-beat flag, qualified by `s_valid`.
- `s_data`  in  N*W  source i occupies bits [i*W +: W].
- `s_ready`  out  N  per-source ready; at most one bit high.
- `arb_req`  out  N  request vector to the arbiter.
- `arb_grant`  in  N  one-hot grant from the arbiter, registered (one cycle after `arb_req`).
- `m_valid`  out  1  master beat valid.
- `m_data`  out  W  master beat data.
- `m_last`  out  1  master last flag (`s_last` of owner, or forced at beat limit).
- `m_ready`  in  1  master ready.
- `m_src`  out  $clog2(N)  binary index of current owner; valid when `m_valid`.
- `err_trunc`  out  1  one-cycle pulse when a packet is cut at `MAX_BEATS`.

## Operation
- States: IDLE, WAIT, XFER.
- Registers: `owner` (one-hot), `last_owner` (one-hot, 0 after reset), `beat_cnt` ($clog2(MAX_BEATS+1) bits).
- IDLE: `arb_req = |s_valid ? s_valid : last_owner`. If `|s_valid` → WAIT, else stay.
- WAIT: `arb_req = arb_grant` (holds arbiter pointer). If `arb_grant & s_valid` nonzero → latch `owner = arb_grant`, `beat_cnt = 0`, → XFER. Else → IDLE (no latch).
- XFER: `arb_req = owner`; `s_ready = owner & {N{m_ready}}`; `m_valid = |(s_valid & owner)`; `m_data`/`m_src` from owner's index; combinational path source→master.
- Beat accept = `m_valid & m_ready`; increments `beat_cnt`.
- Packet end on accepted beat with owner `s_last`, or on the accepted beat that makes `beat_cnt == MAX_BEATS` (then `m_last` forced 1, `err_trunc` pulses next cycle if owner `s_last` was 0). On end: `last_owner = owner`, → IDLE.
- Non-XFER states: `s_ready = 0`, `m_valid = 0`, `m_last = 0`.
- Owner never changes mid-packet regardless of other `s_valid` or `arb_grant` activity.
- Truncated remainder of a source is treated as a new packet in later arbitration.
- Non-one-hot `arb_grant` in WAIT: lowest set bit of `arb_grant & s_valid` is used.

## Timing
- Reset (sync, `rst`=1 at edge): state IDLE, `owner`=0, `last_owner`=0, `beat_cnt`=0, `err_trunc`=0; combinational outputs then `s_ready`=0, `m_valid`=0, `m_last`=0, `arb_req`=0 when no `s_valid`. Reset mid-packet abandons the packet; no partial completion.
- Latency: `s_valid` rising in IDLE at cycle t → WAIT t+1 → first beat presentable at t+2.
- Throughput in XFER: one beat/cycle when `m_ready`=1 and owner valid.
- Inter-packet gap: ≥2 cycles (IDLE, WAIT) after last beat.
- `err_trunc`: registered, high exactly one cycle after the truncating beat.
- Arbiter grant is back on `owner` one cycle after XFER entry and stays there until IDLE, so next arbitration starts from the previous owner.

## Test plan
- Single source 2 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), `m_ready`=1 → first beat 2 cycles after valid, `m_src`=2, three consecutive beats, `m_last` on 0xA3, `s_ready[2]` only.
- Sources 0,1,3 continuously valid with 2-beat packets → owner order 0,1,3,0,1,3…; no source starved; each packet contiguous.
- Source 4 mid-packet, source 0 asserts valid; `m_ready` toggled 1,0,1,0 → no interleaving; data stable while `m_ready`=0; owner switches only after source 4 last.
- MAX_BEATS=4, source 1 sends 6 beats without `s_last` until beat 6 → `m_last` forced on beat 4, `err_trunc` one pulse next cycle, beats 5–6 delivered as new packet ending with `m_last`.
- `rst` asserted during beat 2 of a 5-beat packet → next cycle `m_valid`=0, `s_ready`=0, state IDLE; after release, still-valid source re-arbitrates from index 0 with `last_owner`=0.
- All sources idle for 10 cycles after packet from source 3, then sources 3 and 4 valid → `arb_req` holds 0b01000 during idle; source 4 wins next.
